// File: rtl/hb_interp_sequencer.sv
// Rate/phase sequencer for the x2 halfband interpolator cascade: per-stage clock enables,
// input ready strobe, flush/drain phases and sticky underrun. Optional sample counter: HB_SEQ_SAMPLE_CNT_EN.
module hb_interp_sequencer #(
    parameter int g_stages       = 3,
    parameter int g_flush_cycles = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_en,
    input  logic [1:0]          io_mode,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    output logic [g_stages-1:0] io_stage_ce,
    output logic                io_out_valid,
    output logic                io_busy,
    output logic                io_underrun,
    output logic [1:0]          io_state
`ifdef HB_SEQ_SAMPLE_CNT_EN
    ,
    output logic [15:0]         io_sample_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int FW = (g_flush_cycles < 2) ? 1 : $clog2(g_flush_cycles);
    localparam logic [FW-1:0] FLAST = FW'(g_flush_cycles - 1);

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [FW-1:0]       r_fcnt;
    logic [1:0]          r_mode;
    logic                r_ready;
    logic [g_stages-1:0] r_ce;
    logic                r_oval;
    logic                r_busy;
    logic                r_under;

    state_t              w_state_nxt;
    logic [2:0]          w_cnt_nxt;
    logic [2:0]          w_cnt_wrap;
    logic [FW-1:0]       w_fcnt_nxt;
    logic [1:0]          w_mode_nxt;
    logic                w_start;
    logic                w_flast;
    logic                w_ready_nxt;
    logic [g_stages-1:0] w_ce_nxt;
    logic                w_under_nxt;

    // Outputs are decoded from the next state so they line up with io_state.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_fcnt_nxt  = r_fcnt;
        w_start     = 1'b0;
        w_flast     = (r_mode == 2'd0) || (r_fcnt == FLAST);
        w_cnt_wrap  = 3'((1 << r_mode) - 1);
        w_cnt_nxt   = 3'd0;
        w_ce_nxt    = '0;
        w_under_nxt = r_under;

        case (r_state)
            S_IDLE: begin
                if (io_en) begin
                    w_state_nxt = S_FLUSH;
                    w_mode_nxt  = io_mode;
                    w_fcnt_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            S_FLUSH: begin
                if (!io_en) begin
                    w_state_nxt = S_IDLE;
                    w_fcnt_nxt  = '0;
                end else if (w_flast) begin
                    w_state_nxt = S_RUN;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!io_en) begin
                    w_state_nxt = S_DRAIN;
                    w_fcnt_nxt  = '0;
                end
            end
            S_DRAIN: begin
                if (w_flast) begin
                    w_state_nxt = S_IDLE;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_state != S_IDLE && w_state_nxt != S_IDLE && r_cnt != w_cnt_wrap) begin
            w_cnt_nxt = r_cnt + 3'd1;
        end

        w_ready_nxt = (w_state_nxt == S_FLUSH || w_state_nxt == S_RUN) && (w_cnt_nxt == 3'd0);

        // Stage k runs at 2^(k+1) times the input rate; the last active stage every cycle.
        for (int k = 0; k < g_stages; k++) begin
            if (w_state_nxt != S_IDLE && k < int'(w_mode_nxt)) begin
                if ((w_cnt_nxt & 3'((1 << (int'(w_mode_nxt) - 1 - k)) - 1)) == 3'd0) begin
                    w_ce_nxt[k] = 1'b1;
                end
            end
        end

        if (w_start) begin
            w_under_nxt = 1'b0;
        end else if (r_ready && !io_in_valid) begin
            w_under_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_mode  <= '0;
            r_ready <= 1'b0;
            r_ce    <= '0;
            r_oval  <= 1'b0;
            r_busy  <= 1'b0;
            r_under <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_mode  <= w_mode_nxt;
            r_ready <= w_ready_nxt;
            r_ce    <= w_ce_nxt;
            r_oval  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_under <= w_under_nxt;
        end
    end

`ifdef HB_SEQ_SAMPLE_CNT_EN
    logic [15:0] r_scnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scnt <= '0;
        end else if (w_start) begin
            r_scnt <= '0;
        end else if (r_ready && io_in_valid) begin
            r_scnt <= r_scnt + 16'd1;
        end
    end

    assign io_sample_cnt = r_scnt;
`endif

    assign io_in_ready  = r_ready;
    assign io_stage_ce  = r_ce;
    assign io_out_valid = r_oval;
    assign io_busy      = r_busy;
    assign io_underrun  = r_under;
    assign io_state     = r_state;

endmodule

// File: tb/tb_hb_interp_sequencer.sv
// Scoreboard bench for hb_interp_sequencer: a cycle model predicts each output cycle,
// predictions are queued before the clock edge and compared just after it.
module tb_hb_interp_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_en = 1'b0;
    logic [1:0]  io_mode = 2'd0;
    logic        io_in_valid = 1'b1;
    logic        io_in_ready;
    logic [2:0]  io_stage_ce;
    logic        io_out_valid;
    logic        io_busy;
    logic        io_underrun;
    logic [1:0]  io_state;
`ifdef HB_SEQ_SAMPLE_CNT_EN
    logic [15:0] io_sample_cnt;
`endif

    hb_interp_sequencer #(.g_stages(3), .g_flush_cycles(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_en        (io_en),
        .io_mode      (io_mode),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_stage_ce  (io_stage_ce),
        .io_out_valid (io_out_valid),
        .io_busy      (io_busy),
        .io_underrun  (io_underrun),
        .io_state     (io_state)
`ifdef HB_SEQ_SAMPLE_CNT_EN
        ,
        .io_sample_cnt(io_sample_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  st;
        logic        rdy;
        logic [2:0]  ce;
        logic        ov;
        logic        busy;
        logic        und;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int          m_state = 0;
    int          m_pos = 0;
    int          m_el = 0;
    int          m_mode = 0;
    logic        m_und = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] m_scnt = 16'd0;

    // Observed-output tallies for segment checks
    int obs_rdy = 0;
    int obs_ov = 0;
    int obs_drain = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t got;
        int r;
        int f;
        if (reset) begin
            m_state = 0; m_pos = 0; m_el = 0; m_mode = 0;
            m_und = 1'b0; m_scnt = 16'd0;
        end else begin
            r = 1 << m_mode;
            f = (m_mode == 0) ? 1 : 16;
            if (m_state != 0 && m_ready) begin
                if (!io_in_valid) m_und = 1'b1;
                else              m_scnt = m_scnt + 16'd1;
            end
            case (m_state)
                0: if (io_en) begin
                    m_state = 1; m_mode = int'(io_mode); m_el = 0; m_pos = 0;
                    m_und = 1'b0; m_scnt = 16'd0;
                end
                1: begin
                    m_el++;
                    m_pos = (m_pos + 1) % r;
                    if (!io_en) begin
                        m_state = 0; m_pos = 0;
                    end else if (m_el == f) begin
                        m_state = 2; m_el = 0;
                    end
                end
                2: begin
                    m_pos = (m_pos + 1) % r;
                    if (!io_en) begin
                        m_state = 3; m_el = 0;
                    end
                end
                default: begin
                    m_el++;
                    m_pos = (m_pos + 1) % r;
                    if (m_el == f) begin
                        m_state = 0; m_pos = 0;
                    end
                end
            endcase
        end
        e.st   = 2'(m_state);
        e.rdy  = (m_state == 1 || m_state == 2) && (m_pos == 0);
        e.ce   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (m_state != 0 && k < m_mode && (m_pos % (1 << (m_mode - 1 - k))) == 0)
                e.ce[k] = 1'b1;
        end
        e.ov   = (m_state >= 2);
        e.busy = (m_state != 0);
        e.und  = m_und;
        e.sc   = m_scnt;
        m_ready = e.rdy;
        q.push_back(e);

        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            got = q.pop_front();
            chk("state",     32'(io_state),     32'(got.st));
            chk("in_ready",  32'(io_in_ready),  32'(got.rdy));
            chk("stage_ce",  32'(io_stage_ce),  32'(got.ce));
            chk("out_valid", 32'(io_out_valid), 32'(got.ov));
            chk("busy",      32'(io_busy),      32'(got.busy));
            chk("underrun",  32'(io_underrun),  32'(got.und));
`ifdef HB_SEQ_SAMPLE_CNT_EN
            chk("sample_cnt", 32'(io_sample_cnt), 32'(got.sc));
`endif
        end
        obs_rdy   += int'(io_in_ready);
        obs_ov    += int'(io_out_valid);
        obs_drain += (io_state == 2'd3) ? 1 : 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit done;

        // Reset
        reset = 1'b1; io_en = 1'b1; io_mode = 2'd3;
        steps(3);
        chk("rst_state", 32'(io_state), 32'd0);
        reset = 1'b0; io_en = 1'b0;
        steps(2);

        // x8 continuous run, then drain
        io_mode = 2'd3; io_en = 1'b1; io_in_valid = 1'b1;
        steps(17);
        chk("t1_run_after_flush", 32'(io_state), 32'd2);
        obs_rdy = 0;
        steps(32);
        chk("t1_ready_per_32", 32'(obs_rdy), 32'd4);
        io_en = 1'b0;
        steps(20);

        // Bypass
        io_mode = 2'd0; io_en = 1'b1;
        steps(2);
        chk("t2_oval_cycle2", 32'(io_out_valid), 32'd1);
        steps(8);
        io_en = 1'b0;
        steps(4);

        // x2 with one missed sample
        io_mode = 2'd1; io_en = 1'b1; done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            io_in_valid = !(i >= 20 && !done && m_ready);
            if (!io_in_valid) done = 1'b1;
            step();
        end
        io_in_valid = 1'b1;
        chk("t3_underrun_set", 32'(io_underrun), 32'd1);
        io_en = 1'b0;
        steps(20);
        chk("t3_underrun_idle", 32'(io_underrun), 32'd1);
        io_en = 1'b1;
        steps(2);
        chk("t3_underrun_clear", 32'(io_underrun), 32'd0);
        io_en = 1'b0;
        steps(4);

        // x4 drain, with io_en re-raised mid-drain
        io_mode = 2'd2; io_en = 1'b1;
        steps(24);
        io_en = 1'b0; obs_drain = 0;
        steps(5);
        io_en = 1'b1;
        steps(14);
        chk("t4_drain_len", 32'(obs_drain), 32'd16);
        steps(3);
        io_en = 1'b0;
        steps(20);

        // Abort in FLUSH; mode change ignored in RUN
        io_mode = 2'd1; io_en = 1'b1; obs_ov = 0;
        steps(5);
        io_en = 1'b0;
        steps(4);
        chk("t5_no_oval", 32'(obs_ov), 32'd0);
        io_en = 1'b1;
        steps(20);
        io_mode = 2'd3;
        obs_rdy = 0;
        steps(16);
        chk("t5_ratio_x2", 32'(obs_rdy), 32'd8);

        // Reset in RUN
        reset = 1'b1;
        step();
        chk("t6_rst_busy", 32'(io_busy), 32'd0);
        reset = 1'b0; io_en = 1'b0;
        steps(2);

`ifdef HB_SEQ_SAMPLE_CNT_EN
        io_mode = 2'd0; io_en = 1'b1; io_in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) step();
        io_en = 1'b0;
        steps(4);
        chk("t6_cnt_wrap", 32'(io_sample_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
